// File: rtl/instr_sequencer.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky trap.
// Optional retired-instruction counter enabled by INSTR_SEQUENCER_INSTRET_EN.

package instr_sequencer_pkg;
  typedef enum logic [3:0] {
    invalid,
    lui,
    auipc,
    jal,
    jalr,
    branch_type,
    load_type,
    store_type,
    imm_arith_type,
    reg_arith_type,
    fence_type,
    system_type
  } opcode_t;
endpackage

module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        o_imem_req,
  input  logic        i_imem_ack,
  output logic        o_ir_we,
  input  opcode_t     i_opcode_type,
  input  logic        i_branch_taken,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  input  logic        i_dmem_ack,
  output logic        o_pc_we,
  output logic [1:0]  o_pc_sel,
  output logic        o_rd_we,
  output logic [1:0]  o_wb_sel,
  output logic        o_retire,
  output logic        o_trap,
  output logic [1:0]  o_trap_cause,
  output logic [63:0] o_instret
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_JAL   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;
  localparam logic [1:0] PC_BR    = 2'd3;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_IMM  = 2'd3;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd0;
  localparam logic [1:0] CAUSE_SYSTEM  = 2'd1;
  localparam logic [1:0] CAUSE_IMEM    = 2'd2;
  localparam logic [1:0] CAUSE_DMEM    = 2'd3;

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [1:0]       r_pc_sel;
  logic [1:0]       r_wb_sel;
  logic [1:0]       r_cause;
  logic             r_is_store;
  logic [1:0]       w_pc_sel_nxt;
  logic [1:0]       w_wb_sel_nxt;
  logic [1:0]       w_cause_nxt;
  logic             w_is_store_nxt;
  logic             w_timeout;

  assign w_timeout = (TIMEOUT != 0) && (r_wait_cnt == CNT_W'(TIMEOUT));

  // State and per-instruction context registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_BOOT;
      r_pc_sel   <= PC_PLUS4;
      r_wb_sel   <= WB_ALU;
      r_cause    <= CAUSE_ILLEGAL;
      r_is_store <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_pc_sel   <= w_pc_sel_nxt;
      r_wb_sel   <= w_wb_sel_nxt;
      r_cause    <= w_cause_nxt;
      r_is_store <= w_is_store_nxt;
    end
  end

  // Handshake wait counter; cleared on every state change so each wait starts at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (w_next != r_state) begin
      r_wait_cnt <= '0;
    end else if ((r_state == S_FETCH || r_state == S_MEM) && (TIMEOUT != 0)) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  // Next-state and output decode; acks are only looked at in FETCH/MEM
  always_comb begin
    w_next         = r_state;
    w_pc_sel_nxt   = r_pc_sel;
    w_wb_sel_nxt   = r_wb_sel;
    w_cause_nxt    = r_cause;
    w_is_store_nxt = r_is_store;
    o_imem_req     = 1'b0;
    o_ir_we        = 1'b0;
    o_dmem_req     = 1'b0;
    o_dmem_we      = 1'b0;
    o_pc_we        = 1'b0;
    o_pc_sel       = PC_PLUS4;
    o_rd_we        = 1'b0;
    o_wb_sel       = WB_ALU;
    o_retire       = 1'b0;
    o_trap         = 1'b0;
    o_trap_cause   = 2'd0;

    case (r_state)
      S_BOOT: w_next = S_FETCH;

      S_FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ack) begin
          o_ir_we = 1'b1;
          w_next  = S_DECODE;
        end else if (w_timeout) begin
          w_next      = S_TRAP;
          w_cause_nxt = CAUSE_IMEM;
        end
      end

      S_DECODE: w_next = S_EXEC;

      S_EXEC: begin
        w_pc_sel_nxt   = PC_PLUS4;
        w_wb_sel_nxt   = WB_ALU;
        w_is_store_nxt = 1'b0;
        case (i_opcode_type)
          lui: begin
            w_wb_sel_nxt = WB_IMM;
            w_next       = S_WB;
          end
          auipc, imm_arith_type, reg_arith_type: w_next = S_WB;
          jal: begin
            w_pc_sel_nxt = PC_JAL;
            w_wb_sel_nxt = WB_PC4;
            w_next       = S_WB;
          end
          jalr: begin
            w_pc_sel_nxt = PC_JALR;
            w_wb_sel_nxt = WB_PC4;
            w_next       = S_WB;
          end
          branch_type: begin
            o_pc_we  = 1'b1;
            o_retire = 1'b1;
            o_pc_sel = i_branch_taken ? PC_BR : PC_PLUS4;
            w_next   = S_FETCH;
          end
          load_type: begin
            w_wb_sel_nxt = WB_LOAD;
            w_next       = S_MEM;
          end
          store_type: begin
            w_is_store_nxt = 1'b1;
            w_next         = S_MEM;
          end
          fence_type: begin
            o_pc_we  = 1'b1;
            o_retire = 1'b1;
            w_next   = S_FETCH;
          end
          system_type: begin
            w_cause_nxt = CAUSE_SYSTEM;
            w_next      = S_TRAP;
          end
          default: begin
            w_cause_nxt = CAUSE_ILLEGAL;
            w_next      = S_TRAP;
          end
        endcase
      end

      S_MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = r_is_store;
        o_pc_sel   = r_pc_sel;
        o_wb_sel   = r_wb_sel;
        if (i_dmem_ack) begin
          if (r_is_store) begin
            o_pc_we  = 1'b1;
            o_retire = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (w_timeout) begin
          w_next      = S_TRAP;
          w_cause_nxt = CAUSE_DMEM;
        end
      end

      S_WB: begin
        o_rd_we  = 1'b1;
        o_pc_we  = 1'b1;
        o_retire = 1'b1;
        o_pc_sel = r_pc_sel;
        o_wb_sel = r_wb_sel;
        w_next   = S_FETCH;
      end

      S_TRAP: begin
        o_trap       = 1'b1;
        o_trap_cause = r_cause;
      end

      default: w_next = S_BOOT;
    endcase
  end

`ifdef INSTR_SEQUENCER_INSTRET_EN
  logic [63:0] r_instret;

  // Free-running retire count, wraps naturally at 2^64
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instret <= '0;
    end else if (o_retire) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  assign o_instret = r_instret;
`else
  assign o_instret = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer (TIMEOUT = 4).
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_imem_ack, i_dmem_ack, i_branch_taken;
  opcode_t     i_opcode_type;
  logic        o_imem_req, o_ir_we, o_dmem_req, o_dmem_we, o_pc_we, o_rd_we, o_retire, o_trap;
  logic [1:0]  o_pc_sel, o_wb_sel, o_trap_cause;
  logic [63:0] o_instret;
  logic [13:0] obs;
  logic [13:0] e;
  logic [63:0] exp_cnt;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  instr_sequencer #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .o_imem_req(o_imem_req), .i_imem_ack(i_imem_ack), .o_ir_we(o_ir_we),
    .i_opcode_type(i_opcode_type), .i_branch_taken(i_branch_taken),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .i_dmem_ack(i_dmem_ack),
    .o_pc_we(o_pc_we), .o_pc_sel(o_pc_sel), .o_rd_we(o_rd_we), .o_wb_sel(o_wb_sel),
    .o_retire(o_retire), .o_trap(o_trap), .o_trap_cause(o_trap_cause), .o_instret(o_instret)
  );

  assign obs = {o_imem_req, o_ir_we, o_dmem_req, o_dmem_we, o_pc_we, o_pc_sel,
                o_rd_we, o_wb_sel, o_retire, o_trap, o_trap_cause};

  // Expected output vector in the same field order as obs
  function automatic logic [13:0] ev(input int ireq, input int irw, input int dreq, input int dwe,
                                     input int pwe, input int psel, input int rwe, input int wsel,
                                     input int ret, input int trp, input int cause);
    return {1'(ireq), 1'(irw), 1'(dreq), 1'(dwe), 1'(pwe), 2'(psel),
            1'(rwe), 2'(wsel), 1'(ret), 1'(trp), 2'(cause)};
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    i_imem_ack = 1'b0; i_dmem_ack = 1'b0; i_branch_taken = 1'b0; i_opcode_type = invalid;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Advance one cycle, drive this cycle's inputs, let outputs settle
  task automatic cyc(input int ia, input int da, input opcode_t op, input int bt);
    @(posedge clk);
    #1;
    i_imem_ack = 1'(ia); i_dmem_ack = 1'(da); i_opcode_type = op; i_branch_taken = 1'(bt);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_imem_ack = 1'b1; i_dmem_ack = 1'b1; i_opcode_type = store_type; i_branch_taken = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    e = ev(0,0,0,0,0,0,0,0,0,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL in_reset got %b want %b", obs, e); end
    checks++; if (o_instret !== 64'd0) begin errors++; $display("FAIL reset_instret got %0d want 0", o_instret); end
    rst = 1'b0;
    #1;
    e = ev(0,0,0,0,0,0,0,0,0,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL boot_idle got %b want %b", obs, e); end
    cyc(0, 0, invalid, 0);
    e = ev(1,0,0,0,0,0,0,0,0,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL first_fetch got %b want %b", obs, e); end
  endtask

  task automatic test_alu_back_to_back();
    apply_reset();
    cyc(1, 0, imm_arith_type, 0);
    e = ev(1,1,0,0,0,0,0,0,0,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL addi_fetch got %b want %b", obs, e); end
    cyc(1, 1, imm_arith_type, 0);
    e = ev(0,0,0,0,0,0,0,0,0,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL decode_stray_ack got %b want %b", obs, e); end
    cyc(0, 0, imm_arith_type, 0);
    cyc(0, 0, imm_arith_type, 0);
    e = ev(0,0,0,0,1,0,1,0,1,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL addi_wb got %b want %b", obs, e); end
    checks++; if (o_instret !== 64'd0) begin errors++; $display("FAIL instret_before got %0d want 0", o_instret); end
    cyc(1, 0, lui, 0);
    e = ev(1,1,0,0,0,0,0,0,0,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL lui_fetch got %b want %b", obs, e); end
    cyc(0, 0, lui, 0);
    cyc(0, 0, lui, 0);
    cyc(0, 0, lui, 0);
    e = ev(0,0,0,0,1,0,1,3,1,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL lui_wb got %b want %b", obs, e); end
    cyc(0, 0, lui, 0);
    e = ev(1,0,0,0,0,0,0,0,0,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL next_fetch got %b want %b", obs, e); end
`ifdef INSTR_SEQUENCER_INSTRET_EN
    exp_cnt = 64'd2;
`else
    exp_cnt = 64'd0;
`endif
    checks++; if (o_instret !== exp_cnt) begin errors++; $display("FAIL instret_two got %0d want %0d", o_instret, exp_cnt); end
  endtask

  task automatic test_jump();
    apply_reset();
    cyc(1, 0, jal, 0);
    cyc(0, 0, jal, 0);
    cyc(0, 0, jal, 0);
    cyc(0, 0, jal, 0);
    e = ev(0,0,0,0,1,1,1,2,1,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL jal_wb got %b want %b", obs, e); end
    cyc(1, 0, jalr, 0);
    cyc(0, 0, jalr, 0);
    cyc(0, 0, jalr, 0);
    cyc(0, 0, jalr, 0);
    e = ev(0,0,0,0,1,2,1,2,1,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL jalr_wb got %b want %b", obs, e); end
  endtask

  task automatic test_load_wait();
    apply_reset();
    cyc(1, 0, load_type, 0);
    cyc(0, 1, load_type, 0);
    e = ev(0,0,0,0,0,0,0,0,0,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL decode_stray_dack got %b want %b", obs, e); end
    cyc(0, 0, load_type, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, (i == 3) ? 1 : 0, load_type, 0);
      e = ev(0,0,1,0,0,0,0,1,0,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL lw_mem%0d got %b want %b", i, obs, e); end
    end
    cyc(0, 0, load_type, 0);
    e = ev(0,0,0,0,1,0,1,1,1,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL lw_wb got %b want %b", obs, e); end
    cyc(0, 0, load_type, 0);
    e = ev(1,0,0,0,0,0,0,0,0,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL lw_next_fetch got %b want %b", obs, e); end
  endtask

  task automatic test_store();
    apply_reset();
    cyc(1, 0, store_type, 0);
    cyc(0, 0, store_type, 0);
    cyc(0, 0, store_type, 0);
    cyc(0, 1, store_type, 0);
    e = ev(0,0,1,1,1,0,0,0,1,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL sw_ack got %b want %b", obs, e); end
    cyc(0, 0, store_type, 0);
    e = ev(1,0,0,0,0,0,0,0,0,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL sw_next_fetch got %b want %b", obs, e); end
  endtask

  task automatic test_branch_fence();
    apply_reset();
    cyc(1, 0, branch_type, 1);
    cyc(0, 0, branch_type, 1);
    cyc(0, 0, branch_type, 1);
    e = ev(0,0,0,0,1,3,0,0,1,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL beq_taken got %b want %b", obs, e); end
    cyc(1, 0, branch_type, 0);
    e = ev(1,1,0,0,0,0,0,0,0,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL bne_fetch got %b want %b", obs, e); end
    cyc(0, 0, branch_type, 0);
    cyc(0, 0, branch_type, 0);
    e = ev(0,0,0,0,1,0,0,0,1,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL bne_not_taken got %b want %b", obs, e); end
    cyc(1, 0, fence_type, 0);
    cyc(0, 0, fence_type, 0);
    cyc(0, 0, fence_type, 0);
    e = ev(0,0,0,0,1,0,0,0,1,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL fence_exec got %b want %b", obs, e); end
    cyc(0, 0, fence_type, 0);
    e = ev(1,0,0,0,0,0,0,0,0,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL fence_next_fetch got %b want %b", obs, e); end
  endtask

  task automatic test_trap();
    apply_reset();
    cyc(1, 0, invalid, 0);
    cyc(0, 0, invalid, 0);
    cyc(0, 0, invalid, 0);
    cyc(0, 0, invalid, 0);
    e = ev(0,0,0,0,0,0,0,0,0,1,0); checks++; if (obs !== e) begin errors++; $display("FAIL illegal_trap got %b want %b", obs, e); end
    for (int i = 0; i < 100; i++) begin
      cyc(i % 2, (i + 1) % 2, store_type, 1);
      e = ev(0,0,0,0,0,0,0,0,0,1,0); checks++; if (obs !== e) begin errors++; $display("FAIL trap_hold%0d got %b want %b", i, obs, e); end
    end
    apply_reset();
    cyc(1, 0, system_type, 0);
    cyc(0, 0, system_type, 0);
    cyc(0, 0, system_type, 0);
    cyc(0, 0, system_type, 0);
    e = ev(0,0,0,0,0,0,0,0,0,1,1); checks++; if (obs !== e) begin errors++; $display("FAIL ecall_trap got %b want %b", obs, e); end
  endtask

  task automatic test_timeout();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, load_type, 0);
      e = ev(1,0,0,0,0,0,0,0,0,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL imem_wait%0d got %b want %b", i, obs, e); end
    end
    cyc(0, 0, load_type, 0);
    e = ev(0,0,0,0,0,0,0,0,0,1,2); checks++; if (obs !== e) begin errors++; $display("FAIL imem_timeout got %b want %b", obs, e); end
    apply_reset();
    for (int i = 0; i < 4; i++) cyc(0, 0, load_type, 0);
    cyc(1, 0, load_type, 0);
    e = ev(1,1,0,0,0,0,0,0,0,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL imem_ack_at_limit got %b want %b", obs, e); end
    cyc(0, 0, load_type, 0);
    e = ev(0,0,0,0,0,0,0,0,0,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL no_trap_after_ack got %b want %b", obs, e); end
    cyc(0, 0, load_type, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, load_type, 0);
      e = ev(0,0,1,0,0,0,0,1,0,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL dmem_wait%0d got %b want %b", i, obs, e); end
    end
    cyc(0, 0, load_type, 0);
    e = ev(0,0,0,0,0,0,0,0,0,1,3); checks++; if (obs !== e) begin errors++; $display("FAIL dmem_timeout got %b want %b", obs, e); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    cyc(1, 0, load_type, 0);
    cyc(0, 0, load_type, 0);
    cyc(0, 0, load_type, 0);
    cyc(0, 0, load_type, 0);
    e = ev(0,0,1,0,0,0,0,1,0,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL mid_mem got %b want %b", obs, e); end
    #1 rst = 1'b1;
    #1;
    e = ev(0,0,0,0,0,0,0,0,0,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL async_reset got %b want %b", obs, e); end
    checks++; if (o_instret !== 64'd0) begin errors++; $display("FAIL async_instret got %0d want 0", o_instret); end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    e = ev(0,0,0,0,0,0,0,0,0,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL boot_after_reset got %b want %b", obs, e); end
    cyc(0, 0, load_type, 0);
    e = ev(1,0,0,0,0,0,0,0,0,0,0); checks++; if (obs !== e) begin errors++; $display("FAIL fetch_after_reset got %b want %b", obs, e); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu_back_to_back();
    test_jump();
    test_load_wait();
    test_store();
    test_branch_fence();
    test_trap();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
